// File: rtl/baccarat_dealer.sv
// Baccarat round controller: deals four cards, applies the third-card tableau, flags the winner.
// Card registers feed external scorers; totals are read back a cycle after each card load.
module baccarat_dealer #(
  parameter int MAX_WAIT = 255
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       start,
  input  logic       card_valid,
  input  logic [3:0] card_in,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic       card_req,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done,
  output logic       error
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2, S_EVAL,
    S_DEAL_P3, S_DECIDE_D, S_DEAL_D3, S_RESULT, S_ERROR
  } state_t;

  state_t     r_state;
  logic [7:0] r_wait;
  logic       r_card_req;
  logic       r_done;
  logic       r_error;
  logic [3:0] r_pcard1, r_pcard2, r_pcard3;
  logic [3:0] r_dcard1, r_dcard2, r_dcard3;

  logic [3:0] w_t;
  logic       w_bdraw;
  logic       w_natural;

  // Banker tableau, keyed on banker total and the player's third-card face value.
  always_comb begin
    w_t       = (r_pcard3 >= 4'd10) ? 4'd0 : r_pcard3;
    w_natural = (pscore >= 4'd8) || (dscore >= 4'd8);
    w_bdraw   = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: w_bdraw = 1'b1;
      4'd3:             w_bdraw = (w_t != 4'd8);
      4'd4:             w_bdraw = (w_t >= 4'd2) && (w_t <= 4'd7);
      4'd5:             w_bdraw = (w_t >= 4'd4) && (w_t <= 4'd7);
      4'd6:             w_bdraw = (w_t >= 4'd6) && (w_t <= 4'd7);
      default:          w_bdraw = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait     <= 8'd0;
      r_card_req <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_pcard1   <= 4'd0;
      r_pcard2   <= 4'd0;
      r_pcard3   <= 4'd0;
      r_dcard1   <= 4'd0;
      r_dcard2   <= 4'd0;
      r_dcard3   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_RESULT, S_ERROR: begin
          if (start) begin
            r_pcard1   <= 4'd0;
            r_pcard2   <= 4'd0;
            r_pcard3   <= 4'd0;
            r_dcard1   <= 4'd0;
            r_dcard2   <= 4'd0;
            r_dcard3   <= 4'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_wait     <= 8'd0;
            r_card_req <= 1'b1;
            r_state    <= S_DEAL_P1;
          end
        end
        S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2, S_DEAL_P3, S_DEAL_D3: begin
          if (card_valid) begin
            r_wait <= 8'd0;
            case (r_state)
              S_DEAL_P1: begin r_pcard1 <= card_in; r_state <= S_DEAL_D1; end
              S_DEAL_D1: begin r_dcard1 <= card_in; r_state <= S_DEAL_P2; end
              S_DEAL_P2: begin r_pcard2 <= card_in; r_state <= S_DEAL_D2; end
              S_DEAL_D2: begin
                r_dcard2   <= card_in;
                r_card_req <= 1'b0;
                r_state    <= S_EVAL;
              end
              S_DEAL_P3: begin
                r_pcard3   <= card_in;
                r_card_req <= 1'b0;
                r_state    <= S_DECIDE_D;
              end
              default: begin
                r_dcard3   <= card_in;
                r_card_req <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= S_RESULT;
              end
            endcase
          end else if (r_wait == 8'(MAX_WAIT - 1)) begin
            r_wait     <= 8'd0;
            r_card_req <= 1'b0;
            r_error    <= 1'b1;
            r_state    <= S_ERROR;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_EVAL: begin
          if (w_natural) begin
            r_done  <= 1'b1;
            r_state <= S_RESULT;
          end else if (pscore <= 4'd5) begin
            r_card_req <= 1'b1;
            r_state    <= S_DEAL_P3;
          end else if (dscore <= 4'd5) begin
            r_card_req <= 1'b1;
            r_state    <= S_DEAL_D3;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_RESULT;
          end
        end
        S_DECIDE_D: begin
          if (w_bdraw) begin
            r_card_req <= 1'b1;
            r_state    <= S_DEAL_D3;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_RESULT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign card_req = r_card_req;
  assign done     = r_done;
  assign error    = r_error;
  assign pcard1   = r_pcard1;
  assign pcard2   = r_pcard2;
  assign pcard3   = r_pcard3;
  assign dcard1   = r_dcard1;
  assign dcard2   = r_dcard2;
  assign dcard3   = r_dcard3;

  // The banker's third card reaches the scorer only as RESULT is entered, so the
  // comparison is taken from the held cards' totals and gated by done.
  assign player_win = r_done && (pscore >= dscore);
  assign dealer_win = r_done && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_dealer.sv
// Randomized baccarat rounds against a rules-level model, checked by a done-triggered scoreboard.
module tb_baccarat_dealer;
  localparam int MAXW = 4;

  logic       slow_clock = 1'b0;
  logic       reset      = 1'b1;
  logic       start      = 1'b0;
  logic       card_valid = 1'b0;
  logic [3:0] card_in    = 4'd0;
  logic [3:0] pscore, dscore;
  logic       card_req, player_win, dealer_win, done, error;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;

  baccarat_dealer #(.MAX_WAIT(MAXW)) dut (
    .slow_clock(slow_clock), .reset(reset), .start(start),
    .card_valid(card_valid), .card_in(card_in), .pscore(pscore), .dscore(dscore),
    .card_req(card_req),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .player_win(player_win), .dealer_win(dealer_win), .done(done), .error(error)
  );

  always #5 slow_clock = ~slow_clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge slow_clock) cyc <= cyc + 1;

  typedef struct { int card; int gap; } deal_t;
  typedef struct { int p1, p2, p3, d1, d2, d3, pw, dw, lat, t0; } exp_t;
  deal_t deck_q[$];
  exp_t  exp_q[$];

  function automatic int cv(input int c);
    return (c >= 10) ? 0 : c;
  endfunction

  // External hand scorers
  assign pscore = 4'((cv(int'(pcard1)) + cv(int'(pcard2)) + cv(int'(pcard3))) % 10);
  assign dscore = 4'((cv(int'(dcard1)) + cv(int'(dcard2)) + cv(int'(dcard3))) % 10);

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Deck: serves queued cards after their programmed idle gap; noise elsewhere.
  initial begin
    deal_t h;
    forever begin
      @(negedge slow_clock);
      if (card_req && deck_q.size() > 0) begin
        h = deck_q[0];
        if (h.gap > 0) begin
          h.gap--;
          deck_q[0]  = h;
          card_valid = 1'b0;
          card_in    = 4'($urandom_range(0, 15));
        end else begin
          card_valid = 1'b1;
          card_in    = 4'(h.card);
          void'(deck_q.pop_front());
        end
      end else if (card_req) begin
        card_valid = 1'b0;
        card_in    = 4'($urandom_range(0, 15));
      end else begin
        card_valid = 1'($urandom_range(0, 1));
        card_in    = 4'($urandom_range(0, 15));
      end
    end
  end

  // Monitor: compares each completed round against the oldest expectation.
  initial begin
    exp_t e;
    logic pd;
    pd = 1'b0;
    forever begin
      @(negedge slow_clock);
      if (done && !pd) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done_queue_size", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("pcard1", int'(pcard1), e.p1);
          chk("pcard2", int'(pcard2), e.p2);
          chk("pcard3", int'(pcard3), e.p3);
          chk("dcard1", int'(dcard1), e.d1);
          chk("dcard2", int'(dcard2), e.d2);
          chk("dcard3", int'(dcard3), e.d3);
          chk("player_win", int'(player_win), e.pw);
          chk("dealer_win", int'(dealer_win), e.dw);
          chk("latency", cyc - e.t0, e.lat);
        end
      end
      pd = done;
    end
  end

  // Plays one hand by the baccarat rules and queues the deck and the expected outcome.
  task automatic run_round(input int c[6], input int g[6], input bit poke);
    exp_t e;
    int pt, bt, n, t;
    bit d3d;
    e = '{default: 0};
    d3d = 1'b0;
    e.p1 = c[0]; e.d1 = c[1]; e.p2 = c[2]; e.d2 = c[3];
    pt = (cv(c[0]) + cv(c[2])) % 10;
    bt = (cv(c[1]) + cv(c[3])) % 10;
    n  = 4;
    if (pt < 8 && bt < 8) begin
      if (pt <= 5) begin
        e.p3 = c[n]; n++;
        t  = cv(e.p3);
        pt = (pt + t) % 10;
        case (bt)
          0, 1, 2: d3d = 1'b1;
          3:       d3d = (t != 8);
          4:       d3d = (t >= 2 && t <= 7);
          5:       d3d = (t >= 4 && t <= 7);
          6:       d3d = (t >= 6 && t <= 7);
          default: d3d = 1'b0;
        endcase
      end else begin
        d3d = (bt <= 5);
      end
      if (d3d) begin
        e.d3 = c[n]; n++;
        bt = (bt + cv(e.d3)) % 10;
      end
    end
    e.pw  = (pt >= bt) ? 1 : 0;
    e.dw  = (bt >= pt) ? 1 : 0;
    e.lat = 6 + ((e.p3 != 0) ? 2 : 0) + (d3d ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      e.lat += g[i];
      deck_q.push_back('{card: c[i], gap: g[i]});
    end
    e.t0 = cyc;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge slow_clock);
    start = 1'b0;
    chk("start_clears_cards",
        int'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 0);
    chk("start_card_req", int'(card_req), 1);
    chk("start_done_low", int'(done), 0);
    if (poke) begin
      @(negedge slow_clock);
      start = 1'b1;
      @(negedge slow_clock);
      start = 1'b0;
    end
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) @(negedge slow_clock);
    chk("round_pending_after_timeout", exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      deck_q.delete();
    end else begin
      @(negedge slow_clock);
      chk("done_held", int'(done), 1);
    end
  endtask

  task automatic random_round(input bit poke);
    int c[6];
    int g[6];
    foreach (c[i]) c[i] = int'($urandom_range(1, 13));
    foreach (g[i]) g[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MAXW - 1)) : 0;
    run_round(c, g, poke);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d expected<50000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c[6];
    int g[6];
    g = '{default: 0};
    repeat (2) @(negedge slow_clock);
    chk("reset_cards", int'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 0);
    chk("reset_flags", int'({card_req, done, error, player_win, dealer_win}), 0);
    reset = 1'b0;
    @(negedge slow_clock);

    c = '{9, 3, 13, 4, 1, 1};  run_round(c, g, 1'b0);
    c = '{2, 3, 3, 3, 6, 1};   run_round(c, g, 1'b0);
    c = '{4, 2, 3, 2, 5, 1};   run_round(c, g, 1'b0);
    c = '{1, 1, 1, 2, 8, 1};   run_round(c, g, 1'b0);
    c = '{10, 3, 7, 4, 1, 1};  run_round(c, g, 1'b0);

    for (int r = 0; r < 30; r++) random_round(r % 3 == 0);

    // Deck timeout after the first card
    deck_q.push_back('{card: 5, gap: 0});
    start = 1'b1;
    @(negedge slow_clock);
    start = 1'b0;
    @(negedge slow_clock);
    chk("err_p1_loaded", int'(pcard1), 5);
    repeat (MAXW - 1) @(negedge slow_clock);
    chk("err_not_yet", int'(error), 0);
    chk("err_req_while_waiting", int'(card_req), 1);
    @(negedge slow_clock);
    chk("err_flag", int'(error), 1);
    chk("err_req_low", int'(card_req), 0);
    chk("err_cards_held", int'(pcard1), 5);
    chk("err_done_wins", int'({done, player_win, dealer_win}), 0);
    repeat (3) @(negedge slow_clock);
    chk("err_sticky", int'(error), 1);

    deck_q.push_back('{card: 7, gap: 0});
    deck_q.push_back('{card: 2, gap: 0});
    start = 1'b1;
    @(negedge slow_clock);
    start = 1'b0;
    chk("err_restart_clear", int'(error), 0);
    chk("err_restart_req", int'(card_req), 1);
    chk("err_restart_cards", int'(pcard1), 0);
    repeat (2) @(negedge slow_clock);
    chk("p2_wait_cards", int'({pcard1, dcard1}), int'({4'd7, 4'd2}));
    chk("p2_wait_req", int'(card_req), 1);

    // Asynchronous reset in DEAL_P2
    #2 reset = 1'b1;
    #1;
    chk("async_reset_cards", int'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 0);
    chk("async_reset_flags", int'({card_req, done, error, player_win, dealer_win}), 0);
    @(negedge slow_clock);
    reset = 1'b0;
    @(negedge slow_clock);
    chk("idle_after_reset", int'({card_req, done, error}), 0);

    for (int r = 0; r < 5; r++) random_round(r == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
